// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the core/debug requesters, the arbiter and the data memory.
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata stable and holds them until *_gnt;
// *_gnt pulses for one cycle, then *_rvalid pulses one cycle later carrying *_rdata/*_err.
interface data_mem_arbiter_if;
    logic        core_req;
    logic        core_we;
    logic [63:0] core_addr;
    logic [63:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic        core_err;
    logic [63:0] core_rdata;

    logic        dbg_req;
    logic        dbg_we;
    logic [63:0] dbg_addr;
    logic [63:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic        dbg_err;
    logic [63:0] dbg_rdata;

    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_err, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        output Mem_Addr, Write_Data, MemWrite, MemRead,
        input  Read_Data
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_err, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        input  Mem_Addr, Write_Data, MemWrite, MemRead,
        output Read_Data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port (core, debug) arbiter onto a single data memory: IDLE -> ACCESS -> DONE per access,
// core-priority with a starvation bound for the debug port, and an address range check.
module data_mem_arbiter #(
    parameter int  MEM_BYTES    = 64,
    parameter int  STARVE_LIMIT = 4,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_arbiter_if.slave bus,
    output logic [1:0]     fsm_state,
    output logic [SW-1:0]  starve_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [63:0]   MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          lat_we;
    logic          lat_err;
    logic          lat_id;      // 1 = debug port owns the current access

    logic          pick_dbg;
    logic          pick_core;
    logic          sel_we;
    logic [63:0]   sel_addr;
    logic [63:0]   sel_wdata;
    logic          sel_err;

    always_comb begin
        pick_dbg  = bus.dbg_req && (!bus.core_req || (starve_cnt == LIMIT));
        pick_core = bus.core_req && !pick_dbg;
        sel_we    = pick_dbg ? bus.dbg_we    : bus.core_we;
        sel_addr  = pick_dbg ? bus.dbg_addr  : bus.core_addr;
        sel_wdata = pick_dbg ? bus.dbg_wdata : bus.core_wdata;
        // Unsigned compare against the last doubleword-aligned start; no wraparound possible.
        sel_err   = sel_addr > MAX_ADDR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            starve_cnt      <= '0;
            lat_we          <= 1'b0;
            lat_err         <= 1'b0;
            lat_id          <= 1'b0;
            bus.core_gnt    <= 1'b0;
            bus.core_rvalid <= 1'b0;
            bus.core_err    <= 1'b0;
            bus.core_rdata  <= '0;
            bus.dbg_gnt     <= 1'b0;
            bus.dbg_rvalid  <= 1'b0;
            bus.dbg_err     <= 1'b0;
            bus.dbg_rdata   <= '0;
            bus.Mem_Addr    <= '0;
            bus.Write_Data  <= '0;
            bus.MemWrite    <= 1'b0;
            bus.MemRead     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.dbg_req || pick_dbg) begin
                        starve_cnt <= '0;
                    end else if (pick_core && (starve_cnt != LIMIT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end

                    if (pick_dbg || pick_core) begin
                        state          <= ACCESS;
                        lat_we         <= sel_we;
                        lat_err        <= sel_err;
                        lat_id         <= pick_dbg;
                        bus.core_gnt   <= pick_core;
                        bus.dbg_gnt    <= pick_dbg;
                        // Mem_Addr/Write_Data double as the latched address and data.
                        bus.Mem_Addr   <= sel_addr;
                        bus.Write_Data <= sel_wdata;
                        bus.MemWrite   <= sel_we && !sel_err;
                        bus.MemRead    <= !sel_we && !sel_err;
                    end
                end

                ACCESS: begin
                    state          <= DONE;
                    bus.core_gnt   <= 1'b0;
                    bus.dbg_gnt    <= 1'b0;
                    bus.Mem_Addr   <= '0;
                    bus.Write_Data <= '0;
                    bus.MemWrite   <= 1'b0;
                    bus.MemRead    <= 1'b0;
                    if (lat_id) begin
                        bus.dbg_rvalid <= 1'b1;
                        bus.dbg_err    <= lat_err;
                        bus.dbg_rdata  <= (lat_we || lat_err) ? 64'd0 : bus.Read_Data;
                    end else begin
                        bus.core_rvalid <= 1'b1;
                        bus.core_err    <= lat_err;
                        bus.core_rdata  <= (lat_we || lat_err) ? 64'd0 : bus.Read_Data;
                    end
                end

                DONE: begin
                    state           <= IDLE;
                    bus.core_rvalid <= 1'b0;
                    bus.dbg_rvalid  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fsm_state    = state;
    assign starve_count = starve_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 64-byte data memory.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  fsm_state;
    logic [2:0]  starve_count;
    logic [63:0] mem [8];
    int          checks;
    int          errors;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(
        .MEM_BYTES   (64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .fsm_state   (fsm_state),
        .starve_count(starve_count)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.Read_Data = mem[bus.Mem_Addr[5:3]];

    always @(negedge clk) begin
        if (bus.MemWrite) mem[bus.Mem_Addr[5:3]] = bus.Write_Data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input bit is_dbg, input bit we, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] exp_rdata,
                             input bit exp_err, input string tag);
        int n;
        bit got;
        @(posedge clk);
        #1;
        if (is_dbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end else begin
            bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata;
        end
        n = 0;
        got = 1'b0;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            got = is_dbg ? bus.dbg_gnt : bus.core_gnt;
        end
        chk({tag, "_gnt"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'd2);
        bus.core_req = 1'b0;
        bus.dbg_req  = 1'b0;
        chk({tag, "_other_gnt"}, 64'(is_dbg ? bus.core_gnt : bus.dbg_gnt), 64'd0);
        chk({tag, "_memread"}, 64'(bus.MemRead), 64'(!we && !exp_err));
        chk({tag, "_memwrite"}, 64'(bus.MemWrite), 64'(we && !exp_err));
        chk({tag, "_mem_addr"}, bus.Mem_Addr, addr);
        chk({tag, "_write_data"}, bus.Write_Data, wdata);
        @(negedge clk);
        chk({tag, "_rvalid"}, 64'(is_dbg ? bus.dbg_rvalid : bus.core_rvalid), 64'd1);
        chk({tag, "_other_rvalid"}, 64'(is_dbg ? bus.core_rvalid : bus.dbg_rvalid), 64'd0);
        chk({tag, "_rdata"}, is_dbg ? bus.dbg_rdata : bus.core_rdata, exp_rdata);
        chk({tag, "_err"}, 64'(is_dbg ? bus.dbg_err : bus.core_err), 64'(exp_err));
        chk({tag, "_gnt_low"}, 64'(bus.core_gnt | bus.dbg_gnt), 64'd0);
        chk({tag, "_strobes_low"}, 64'({bus.MemRead, bus.MemWrite}), 64'd0);
        chk({tag, "_addr_idle"}, bus.Mem_Addr, 64'd0);
        @(negedge clk);
        chk({tag, "_rvalid_drop"}, 64'(is_dbg ? bus.dbg_rvalid : bus.core_rvalid), 64'd0);
        chk({tag, "_rdata_hold"}, is_dbg ? bus.dbg_rdata : bus.core_rdata, exp_rdata);
    endtask

    initial begin
        int grants;
        int cyc;
        int exp_cnt;
        bit got;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) mem[i] = 64'h0;
        mem[1] = 64'd5;
        mem[7] = 64'hA5A5_0000_5A5A_FFFF;
        reset = 1'b1;
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'(fsm_state), 64'd0);
        chk("rst_starve", 64'(starve_count), 64'd0);
        chk("rst_handshake", 64'({bus.core_gnt, bus.core_rvalid, bus.core_err,
                                 bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_err}), 64'd0);
        chk("rst_rdata", bus.core_rdata | bus.dbg_rdata, 64'd0);
        chk("rst_mem_bus", bus.Mem_Addr | bus.Write_Data, 64'd0);
        chk("rst_strobes", 64'({bus.MemRead, bus.MemWrite}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // basic reads/writes and range boundary
        do_access(1'b0, 1'b0, 64'd8,  64'd0, 64'd5, 1'b0, "core_rd8");
        do_access(1'b1, 1'b1, 64'd40, 64'h1122334455667788, 64'd0, 1'b0, "dbg_wr40");
        do_access(1'b0, 1'b0, 64'd40, 64'd0, 64'h1122334455667788, 1'b0, "core_rd40");
        do_access(1'b0, 1'b0, 64'd57, 64'd0, 64'd0, 1'b1, "core_rd57");
        do_access(1'b0, 1'b0, 64'd56, 64'd0, 64'hA5A5_0000_5A5A_FFFF, 1'b0, "core_rd56");
        do_access(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h77, 64'd0, 1'b1, "dbg_wr_huge");
        chk("mem_unchanged_7", mem[7], 64'hA5A5_0000_5A5A_FFFF);

        // starvation bound: both requesters held high
        @(posedge clk);
        #1;
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 64'd8;
        bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b0; bus.dbg_addr  = 64'd16;
        grants = 0;
        cyc = 0;
        exp_cnt = 0;
        while (grants < 10 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.core_gnt || bus.dbg_gnt) begin
                chk($sformatf("starve_order_%0d", grants), 64'(bus.dbg_gnt),
                    64'((grants % 5) == 4));
                exp_cnt = bus.dbg_gnt ? 0 : ((exp_cnt < 4) ? exp_cnt + 1 : 4);
                chk($sformatf("starve_cnt_%0d", grants), 64'(starve_count), 64'(exp_cnt));
                grants++;
            end
        end
        chk("starve_grants", 64'(grants), 64'd10);
        bus.core_req = 1'b0;
        bus.dbg_req  = 1'b0;
        repeat (4) @(negedge clk);

        // reset during the ACCESS cycle of a core write
        @(posedge clk);
        #1;
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 64'd16;
        bus.core_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        cyc = 0;
        got = 1'b0;
        while (cyc < 8 && !got) begin
            @(negedge clk);
            cyc++;
            got = bus.core_gnt;
        end
        chk("rstacc_gnt", 64'(got), 64'd1);
        chk("rstacc_memwrite", 64'(bus.MemWrite), 64'd1);
        bus.core_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rstacc_rvalid", 64'(bus.core_rvalid | bus.dbg_rvalid), 64'd0);
        chk("rstacc_gnt_low", 64'(bus.core_gnt | bus.dbg_gnt), 64'd0);
        chk("rstacc_strobes", 64'({bus.MemRead, bus.MemWrite}), 64'd0);
        chk("rstacc_bus", bus.Mem_Addr | bus.Write_Data, 64'd0);
        chk("rstacc_rdata_err", bus.core_rdata | 64'(bus.core_err), 64'd0);
        chk("rstacc_state", 64'(fsm_state), 64'd0);
        chk("rstacc_write_kept", mem[2], 64'hDEAD_BEEF_0BAD_F00D);
        @(posedge clk);
        #1 reset = 1'b0;
        do_access(1'b0, 1'b0, 64'd16, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, "post_rst_rd16");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
